elevator: RTL and testbench

- Single-car controller for an 8-floor elevator (floors 0..7).
- Latches floor requests presented with a one-cycle request strobe into a pending-request bitmap.
- Moves the car one floor at a time using a direction-preserving (SCAN) policy.
- Opens the door for a fixed time at each requested floor; reports current floor and door state to the top-level panel/display logic.

---
 rtl/elevator_if.sv | 11 +
 rtl/elevator.sv | 135 +++++++++++++
 tb/tb_elevator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/elevator_if.sv
// Panel-side bundle of the elevator controller: floor request strobe in,
// car position and door state out.
interface elevator_if;
    logic [2:0] floor_no;
    logic       ip;
    logic [2:0] curr_floor;
    logic       door;

    modport master (output floor_no, output ip, input curr_floor, input door);
    modport slave  (input floor_no, input ip, output curr_floor, output door);
endinterface

// File: rtl/elevator.sv
// Single-car, 8-floor elevator controller with SCAN (direction-preserving)
// scheduling, timed travel between floors and a timed door dwell per stop.
module elevator #(
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    elevator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

    state_t        state_r, state_nxt_s;
    dir_t          dir_r, dir_nxt_s;
    logic [7:0]    req_r, req_nxt_s;
    logic [TW-1:0] timer_r, timer_nxt_s;
    logic [2:0]    curr_floor_r, floor_nxt_s;
    logic          door_r, door_nxt_s;
    logic          above_s, below_s, here_s, clear_s;

    assign bus.curr_floor = curr_floor_r;
    assign bus.door       = door_r;

    // Pending-request summary relative to the car position
    always_comb begin
        above_s = 1'b0;
        below_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            above_s = above_s | (req_r[i] & (3'(i) > curr_floor_r));
            below_s = below_s | (req_r[i] & (3'(i) < curr_floor_r));
        end
        here_s = req_r[curr_floor_r];
    end

    // Next-state, motion and door decisions
    always_comb begin
        state_nxt_s = state_r;
        dir_nxt_s   = dir_r;
        timer_nxt_s = timer_r;
        floor_nxt_s = curr_floor_r;
        door_nxt_s  = door_r;
        clear_s     = 1'b0;
        case (state_r)
            IDLE: begin
                timer_nxt_s = {TW{1'b0}};
                if (here_s) begin
                    state_nxt_s = DOOR_OPEN;
                    door_nxt_s  = 1'b1;
                    clear_s     = 1'b1;
                end else if ((dir_r == DIR_UP) && above_s) begin
                    state_nxt_s = MOVE_UP;
                end else if (below_s) begin
                    state_nxt_s = MOVE_DOWN;
                    dir_nxt_s   = DIR_DOWN;
                end else if (above_s) begin
                    state_nxt_s = MOVE_UP;
                    dir_nxt_s   = DIR_UP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (here_s) begin
                    state_nxt_s = DOOR_OPEN;
                    door_nxt_s  = 1'b1;
                    clear_s     = 1'b1;
                    timer_nxt_s = {TW{1'b0}};
                end else if ((state_r == MOVE_UP) ? !above_s : !below_s) begin
                    state_nxt_s = IDLE;
                    timer_nxt_s = {TW{1'b0}};
                end else if (timer_r == MOVE_LAST) begin
                    // Guarded by above/below, so the floor can never wrap
                    floor_nxt_s = (state_r == MOVE_UP) ? curr_floor_r + 3'd1 : curr_floor_r - 3'd1;
                    timer_nxt_s = {TW{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            DOOR_OPEN: begin
                if (timer_r == DOOR_LAST) begin
                    door_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                    timer_nxt_s = {TW{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                door_nxt_s  = 1'b0;
                timer_nxt_s = {TW{1'b0}};
            end
        endcase
    end

    // Request bitmap update; a stop being serviced wins over a same-edge capture
    always_comb begin
        req_nxt_s = req_r;
        if (bus.ip && !((state_r == DOOR_OPEN) && (bus.floor_no == curr_floor_r))) begin
            req_nxt_s[bus.floor_no] = 1'b1;
        end else begin
            req_nxt_s = req_r;
        end
        if (clear_s) begin
            req_nxt_s[curr_floor_r] = 1'b0;
        end else begin
            req_nxt_s = req_nxt_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            dir_r        <= DIR_UP;
            req_r        <= 8'd0;
            timer_r      <= {TW{1'b0}};
            curr_floor_r <= 3'd0;
            door_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dir_r        <= dir_nxt_s;
            req_r        <= req_nxt_s;
            timer_r      <= timer_nxt_s;
            curr_floor_r <= floor_nxt_s;
            door_r       <= door_nxt_s;
        end
    end
endmodule

// File: tb/tb_elevator.sv
// Scoreboard bench for the elevator controller: expected stop floors are
// queued with each request and checked whenever the door opens.
module tb_elevator;
    localparam int MOVE_CYCLES = 2;
    localparam int DOOR_CYCLES = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    logic mon_en;
    logic [2:0] prev_floor;
    logic       prev_door;
    int         door_len;
    int         step_t [5];
    logic [2:0] exp_q [$];

    elevator_if bus ();

    elevator #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Door/motion monitor: pops the scoreboard on every door opening
    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            prev_floor <= bus.curr_floor;
            prev_door  <= bus.door;
            door_len   <= 0;
        end else begin
            if (bus.curr_floor != prev_floor) begin
                check_val("single_step", ({1'b0, bus.curr_floor} + 4'd1 == {1'b0, prev_floor}) ||
                                         ({1'b0, prev_floor} + 4'd1 == {1'b0, bus.curr_floor}), 1);
                check_val("door_shut_moving", bus.door, 0);
            end
            if (bus.door && !prev_door) begin
                check_val("stop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_val("stop_floor", bus.curr_floor, exp_q.pop_front());
            end
            if (bus.door) door_len <= door_len + 1;
            else if (prev_door) begin
                check_val("door_len", door_len, DOOR_CYCLES);
                door_len <= 0;
            end
            prev_floor <= bus.curr_floor;
            prev_door  <= bus.door;
        end
    end

    task automatic request(input logic [2:0] f, input logic expect_stop);
        if (expect_stop) exp_q.push_back(f);
        @(negedge clk);
        bus.floor_no = f;
        bus.ip = 1'b1;
        @(negedge clk);
        bus.ip = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.door) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, n < budget, 1);
    endtask

    task automatic wait_floor(input logic [2:0] f, input int budget);
        int n = 0;
        while (bus.curr_floor != f && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("floor_timeout", n < budget, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
        rst_n = 1'b1; bus.ip = 1'b0; bus.floor_no = 3'd0;
        #13 rst_n = 1'b0;
        #1;
        check_val("rst_floor", bus.curr_floor, 0);
        check_val("rst_door", bus.door, 0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        check_val("idle_floor", bus.curr_floor, 0);
        check_val("idle_door", bus.door, 0);

        // Single up trip with step timing
        request(3'd4, 1'b1);
        step_t[0] = cyc;
        for (int f = 1; f <= 4; f++) begin
            wait_floor(3'(f), 20);
            step_t[f] = cyc;
            if (f > 1) check_val("step_period", step_t[f] - step_t[f-1], MOVE_CYCLES);
        end
        wait_done("trip_timeout", 40);
        check_val("trip_floor", bus.curr_floor, 4);

        // Same-floor request, then re-strobe while the door is open
        request(3'd4, 1'b1);
        check_val("same_door_pre", bus.door, 0);
        @(negedge clk);
        check_val("same_door_open", bus.door, 1);
        request(3'd4, 1'b0);
        wait_done("same_timeout", 20);
        repeat (6) @(negedge clk);
        check_val("same_no_reopen", bus.door, 0);
        check_val("same_floor", bus.curr_floor, 4);

        // Back to floor 0, then SCAN ordering 4,5,6 up and 0 down
        request(3'd0, 1'b1);
        wait_done("home_timeout", 60);
        exp_q.push_back(3'd4); exp_q.push_back(3'd5);
        exp_q.push_back(3'd6); exp_q.push_back(3'd0);
        request(3'd4, 1'b0); @(negedge clk);
        request(3'd6, 1'b0); @(negedge clk);
        request(3'd5, 1'b0); @(negedge clk);
        request(3'd0, 1'b0);
        wait_done("scan_timeout", 200);
        check_val("scan_end", bus.curr_floor, 0);

        // Late request behind a descending car
        request(3'd6, 1'b1);
        wait_done("up6_timeout", 60);
        request(3'd0, 1'b1);
        wait_floor(3'd2, 60);
        request(3'd3, 1'b1);
        wait_done("late_timeout", 100);
        check_val("late_floor", bus.curr_floor, 3);

        // Asynchronous reset while moving up with a request pending
        request(3'd0, 1'b1);
        wait_done("home2_timeout", 60);
        request(3'd5, 1'b0);
        wait_floor(3'd2, 40);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_floor", bus.curr_floor, 0);
        check_val("arst_door", bus.door, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_val("post_rst_floor", bus.curr_floor, 0);
        check_val("post_rst_door", bus.door, 0);
        check_val("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
